// File: rtl/seq_alu_pkg.sv
// Shared op codes, FSM states and decode helpers for the sequential ALU.
package seq_alu_pkg;

  // Base ops: the 4-bit ALU codes, zero-extended into the 5-bit op field.
  localparam logic [4:0] ALU_OP_ADD  = 5'd0;
  localparam logic [4:0] ALU_OP_SUB  = 5'd1;
  localparam logic [4:0] ALU_OP_SLL  = 5'd2;
  localparam logic [4:0] ALU_OP_SLT  = 5'd3;
  localparam logic [4:0] ALU_OP_SLTU = 5'd4;
  localparam logic [4:0] ALU_OP_XOR  = 5'd5;
  localparam logic [4:0] ALU_OP_SRL  = 5'd6;
  localparam logic [4:0] ALU_OP_SRA  = 5'd7;
  localparam logic [4:0] ALU_OP_OR   = 5'd8;
  localparam logic [4:0] ALU_OP_AND  = 5'd9;
  localparam logic [4:0] ALU_OP_EQ   = 5'd10;
  localparam logic [4:0] ALU_OP_NEQ  = 5'd11;
  localparam logic [4:0] ALU_OP_GE   = 5'd12;
  localparam logic [4:0] ALU_OP_GEU  = 5'd13;

  // M ops: {2'b10, funct3}.
  localparam logic [4:0] ALU_OP_MUL    = 5'b10000;
  localparam logic [4:0] ALU_OP_MULH   = 5'b10001;
  localparam logic [4:0] ALU_OP_MULHSU = 5'b10010;
  localparam logic [4:0] ALU_OP_MULHU  = 5'b10011;
  localparam logic [4:0] ALU_OP_DIV    = 5'b10100;
  localparam logic [4:0] ALU_OP_DIVU   = 5'b10101;
  localparam logic [4:0] ALU_OP_REM    = 5'b10110;
  localparam logic [4:0] ALU_OP_REMU   = 5'b10111;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  function automatic logic alu_op_is_md(input logic [4:0] op);
    return op[4] & ~op[3];
  endfunction

endpackage

// File: rtl/seq_alu_md_core.sv
// Iterative radix-2 multiply / restoring divide on operand magnitudes, with sign fixup.
module seq_alu_md_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import seq_alu_pkg::*;

  localparam int unsigned CW = $clog2(XLEN + 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   acc_q, acc_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b, res_mag;
  logic [XLEN:0]     sum, shifted, diff;
  logic [2*XLEN-1:0] prod, prod_s;

  always_comb begin
    a_signed = funct3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    b_signed = funct3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
    a_neg    = a_signed & opa[XLEN-1];
    b_neg    = b_signed & opb[XLEN-1];
    mag_a    = a_neg ? -opa : opa;
    mag_b    = b_neg ? -opb : opb;

    sum     = {1'b0, acc_q} + {1'b0, opnd_q};
    shifted = {acc_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, opnd_q};

    cnt_d  = cnt_q;
    acc_d  = acc_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    f3_d   = f3_q;
    neg_d  = neg_q;

    if (flush) begin
      cnt_d = '0;
    end else if (start) begin
      cnt_d = CW'(XLEN);
      acc_d = '0;
      f3_d  = funct3;
      if (funct3[2]) begin
        lo_d   = mag_a;
        opnd_d = mag_b;
        // A zero divisor keeps the all-ones quotient unsigned; remainder follows the dividend.
        neg_d  = funct3[1] ? a_neg : ((a_neg ^ b_neg) & (opb != '0));
      end else begin
        lo_d   = mag_b;
        opnd_d = mag_a;
        neg_d  = a_neg ^ b_neg;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (!f3_q[2]) begin
        if (lo_q[0]) begin
          acc_d = sum[XLEN:1];
          lo_d  = {sum[0], lo_q[XLEN-1:1]};
        end else begin
          acc_d = {1'b0, acc_q[XLEN-1:1]};
          lo_d  = {acc_q[0], lo_q[XLEN-1:1]};
        end
      end else if (!diff[XLEN]) begin
        acc_d = diff[XLEN-1:0];
        lo_d  = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = shifted[XLEN-1:0];
        lo_d  = {lo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  // Result is taken from the final step's next values so DONE follows the last BUSY cycle.
  always_comb begin
    prod    = {acc_d, lo_d};
    prod_s  = neg_q ? -prod : prod;
    res_mag = f3_q[1] ? acc_d : lo_d;
    if (f3_q[2]) begin
      result = neg_q ? -res_mag : res_mag;
    end else if (f3_q[1:0] == 2'b00) begin
      result = prod_s[XLEN-1:0];
    end else begin
      result = prod_s[2*XLEN-1:XLEN];
    end
  end

  assign done = (cnt_q == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      f3_q   <= '0;
      neg_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      f3_q   <= f3_d;
      neg_q  <= neg_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: base ops with one-cycle registered result, M ops via the iterative core.
module seq_alu #(
  parameter int unsigned XLEN  = 32,
  parameter bit          MD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            inValid,
  output logic            inReady,
  input  logic [4:0]      aluOp,
  input  logic [XLEN-1:0] aluIn1,
  input  logic [XLEN-1:0] aluIn2,
  output logic            outValid,
  input  logic            outReady,
  output logic [XLEN-1:0] aluOut,
  output logic            aluErr,
  output logic            busy
);
  import seq_alu_pkg::*;

  localparam int unsigned SW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] out_q, base_res, md_result;
  logic            err_q, md_done, is_md, op_legal, accept, md_start;
  logic [SW-1:0]   shamt;

  assign shamt    = aluIn2[SW-1:0];
  assign is_md    = alu_op_is_md(aluOp);
  assign op_legal = aluOp[4] ? (is_md && MD_EN) : (aluOp[3:0] <= ALU_OP_GEU[3:0]);
  assign accept   = inValid && inReady && !flush;
  assign md_start = accept && is_md && MD_EN;

  always_comb begin
    base_res = '0;
    case (aluOp)
      ALU_OP_ADD:  base_res = aluIn1 + aluIn2;
      ALU_OP_SUB:  base_res = aluIn1 - aluIn2;
      ALU_OP_SLL:  base_res = aluIn1 << shamt;
      ALU_OP_SLT:  base_res = XLEN'($signed(aluIn1) < $signed(aluIn2));
      ALU_OP_SLTU: base_res = XLEN'(aluIn1 < aluIn2);
      ALU_OP_XOR:  base_res = aluIn1 ^ aluIn2;
      ALU_OP_SRL:  base_res = aluIn1 >> shamt;
      ALU_OP_SRA:  base_res = $unsigned($signed(aluIn1) >>> shamt);
      ALU_OP_OR:   base_res = aluIn1 | aluIn2;
      ALU_OP_AND:  base_res = aluIn1 & aluIn2;
      ALU_OP_EQ:   base_res = XLEN'(aluIn1 == aluIn2);
      ALU_OP_NEQ:  base_res = XLEN'(aluIn1 != aluIn2);
      ALU_OP_GE:   base_res = XLEN'($signed(aluIn1) >= $signed(aluIn2));
      ALU_OP_GEU:  base_res = XLEN'(aluIn1 >= aluIn2);
      default:     base_res = '0;
    endcase
  end

  seq_alu_md_core #(
    .XLEN(XLEN)
  ) u_md_core (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (md_start),
    .funct3 (aluOp[2:0]),
    .opa    (aluIn1),
    .opb    (aluIn2),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (accept) state_d = md_start ? StBusy : StDone;
        StBusy: if (md_done) state_d = StDone;
        StDone: if (outReady) state_d = accept ? (md_start ? StBusy : StDone) : StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    inReady  = (state_q == StIdle) || ((state_q == StDone) && outReady);
    outValid = (state_q == StDone);
    busy     = (state_q == StBusy);
  end

  // Result register holds across flush; only a new base/illegal accept or M completion loads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      err_q <= 1'b0;
    end else if (!flush) begin
      if (accept && !md_start) begin
        out_q <= op_legal ? base_res : '0;
        err_q <= !op_legal;
      end else if ((state_q == StBusy) && md_done) begin
        out_q <= md_result;
        err_q <= 1'b0;
      end
    end
  end

  assign aluOut = out_q;
  assign aluErr = err_q;

endmodule
